// File: rtl/bus85_pkg.sv
// Shared types for the 8085 bus tracer: cycle-type and FSM encodings, HLT opcode,
// and the trace-record width helper.
package bus85_pkg;

  typedef enum logic [2:0] {
    CT_OPF  = 3'd0,
    CT_MRD  = 3'd1,
    CT_MWR  = 3'd2,
    CT_IORD = 3'd3,
    CT_IOWR = 3'd4,
    CT_INTA = 3'd5,
    CT_UNK  = 3'd6
  } cyc_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_PUSH
  } bus_state_t;

  localparam logic [7:0] HLT_OPCODE = 8'h76;
  localparam int         TYPE_W     = 3;

  function automatic int recWidth(int dataSize, int addrSize, int tsSize);
    return TYPE_W + addrSize + dataSize + tsSize;
  endfunction

  // An interrupt acknowledge wins over whatever status the core drove.
  function automatic cyc_type_t decodeType(logic intaSeen, logic [2:0] status);
    if (intaSeen) return CT_INTA;
    case (status)
      3'b011:  return CT_OPF;
      3'b010:  return CT_MRD;
      3'b001:  return CT_MWR;
      3'b110:  return CT_IORD;
      3'b101:  return CT_IOWR;
      default: return CT_UNK;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; head word reads as zero while empty.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_popEn;
  logic             w_pushEn;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_count  = r_count;
  assign o_dout   = o_empty ? '0 : r_mem[r_rdPtr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_popEn  = i_pop && !o_empty;
  assign w_pushEn = i_push && (!o_full || w_popEn);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_popEn)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushEn, w_popEn})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_pushEn && !i_clr) r_mem[r_wrPtr] <= i_din;
  end

endmodule

// File: rtl/bus_trace85.sv
// Bus-cycle tracer for the 8085-compatible core: records one entry per completed machine
// cycle and flags HLT fetch, watchdog timeout and overflow. TRACE_TS_EN adds timestamps.
module bus_trace85
  import bus85_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16,
  parameter int DEPTH    = 16,
  parameter int TOUTCYC  = 150,
  parameter int TSSIZE   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic [DATASIZE-1:0]          i_addrdata,
  input  logic [ADDRSIZE-DATASIZE-1:0] i_addr,
  input  logic                         i_ale,
  input  logic                         i_iom_,
  input  logic                         i_s1,
  input  logic                         i_s0,
  input  logic                         i_rd_,
  input  logic                         i_wr_,
  input  logic                         i_inta_,
  output logic                         o_t_valid,
  input  logic                         i_t_ready,
  output logic [2:0]                   o_t_type,
  output logic [ADDRSIZE-1:0]          o_t_addr,
  output logic [DATASIZE-1:0]          o_t_data,
  output logic [TSSIZE-1:0]            o_t_ts,
  output logic [$clog2(DEPTH):0]       o_t_count,
  output logic                         o_halt,
  output logic                         o_tout,
  output logic                         o_ovf,
  output logic [7:0]                   o_drops
);

`ifdef TRACE_TS_EN
  localparam int TSW = TSSIZE;
`else
  localparam int TSW = 0;
`endif
  localparam int RECW = recWidth(DATASIZE, ADDRSIZE, TSW);
  localparam int WDW  = $clog2(TOUTCYC);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TOUTCYC - 1);

  bus_state_t            r_state;
  logic [ADDRSIZE-1:0]   r_addr;
  logic [DATASIZE-1:0]   r_data;
  logic [2:0]            r_stat;
  logic                  r_inta;
  logic                  r_halt;
  logic                  r_tout;
  logic                  r_ovf;
  logic [7:0]            r_drops;
  logic [WDW-1:0]        r_wd;

  logic                  w_strobe;
  cyc_type_t             w_type;
  logic                  w_push;
  logic                  w_popOk;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic [RECW-1:0]       w_din;
  logic [RECW-1:0]       w_dout;

  assign w_strobe = !i_rd_ || !i_wr_ || !i_inta_;
  assign w_type   = decodeType(r_inta, r_stat);

  // Once HLT has been captured the trace freezes; clr wins over any push or pop.
  assign w_push   = (r_state == ST_PUSH) && !r_halt && !i_clr;
  assign w_popOk  = i_t_ready && !w_empty;
  assign w_drop   = w_push && w_full && !w_popOk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_stat  <= '0;
      r_inta  <= 1'b0;
    end else if (i_ale) begin
      r_state <= ST_ADDR;
      r_addr  <= {i_addr, i_addrdata};
      r_stat  <= {i_iom_, i_s1, i_s0};
      r_inta  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_ADDR: begin
          if (w_strobe) begin
            r_state <= ST_STRB;
            r_data  <= i_addrdata;
            if (!i_inta_) r_inta <= 1'b1;
          end
        end
        ST_STRB: begin
          r_data <= i_addrdata;
          if (!i_inta_) r_inta <= 1'b1;
          if (!w_strobe) r_state <= ST_PUSH;
        end
        ST_PUSH: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_halt  <= 1'b0;
      r_tout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_drops <= '0;
      r_wd    <= '0;
    end else if (i_clr) begin
      r_halt  <= 1'b0;
      r_tout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_drops <= '0;
      r_wd    <= '0;
    end else begin
      if (w_push && (w_type == CT_OPF) && (r_data == DATASIZE'(HLT_OPCODE))) r_halt <= 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
      end
      if (r_state == ST_PUSH) r_wd <= '0;
      else if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
      if (r_wd == WD_MAX) r_tout <= 1'b1;
    end
  end

`ifdef TRACE_TS_EN
  logic [TSSIZE-1:0] r_ts;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_ts <= '0;
    else if (i_clr) r_ts <= '0;
    else            r_ts <= r_ts + 1'b1;
  end

  assign w_din  = {r_ts, w_type, r_addr, r_data};
  assign o_t_ts = w_dout[RECW-1 -: TSSIZE];
`else
  assign w_din  = {w_type, r_addr, r_data};
  assign o_t_ts = '0;
`endif

  trace_fifo #(
    .WIDTH (RECW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_clr),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (i_t_ready),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_t_count)
  );

  assign o_t_valid = !w_empty;
  assign o_t_type  = w_dout[DATASIZE+ADDRSIZE +: 3];
  assign o_t_addr  = w_dout[DATASIZE +: ADDRSIZE];
  assign o_t_data  = w_dout[DATASIZE-1:0];
  assign o_halt    = r_halt;
  assign o_tout    = r_tout;
  assign o_ovf     = r_ovf;
  assign o_drops   = r_drops;

endmodule

// File: tb/tb_bus_trace85.sv
// Directed bench for bus_trace85: vector table of single bus cycles plus hand-written
// sequences for halt, overflow, watchdog, mid-cycle reset and (TRACE_TS_EN) timestamps.
module tb_bus_trace85;

  localparam logic [2:0] OPF = 3'd0, MRD = 3'd1, MWR = 3'd2, IORD = 3'd3,
                         IOWR = 3'd4, INTA = 3'd5, UNK = 3'd6;
  localparam int STB_RD = 0, STB_WR = 1, STB_INTA = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        ale = 1'b0;
  logic        iom_ = 1'b0, s1 = 1'b0, s0 = 1'b0;
  logic        rd_ = 1'b1, wr_ = 1'b1, inta_ = 1'b1;
  logic        tReady = 1'b0;
  logic [7:0]  addrdata = 8'h00;
  logic [7:0]  addrHi = 8'h00;
  logic        tValid;
  logic [2:0]  tType;
  logic [15:0] tAddr;
  logic [7:0]  tData;
  logic [15:0] tTs;
  logic [4:0]  tCount;
  logic        halt, tout, ovf;
  logic [7:0]  drops;

  int nChecks = 0;
  int nFails  = 0;
  int edgeCnt = 0;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] a;
    logic [7:0]  d;
    int          stb;
    int          len;
    logic [2:0]  expType;
    logic [15:0] expAddr;
    logic [7:0]  expData;
  } vec_t;

  vec_t vecs [8];

  bus_trace85 dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (clr),
    .i_addrdata (addrdata),
    .i_addr     (addrHi),
    .i_ale      (ale),
    .i_iom_     (iom_),
    .i_s1       (s1),
    .i_s0       (s0),
    .i_rd_      (rd_),
    .i_wr_      (wr_),
    .i_inta_    (inta_),
    .o_t_valid  (tValid),
    .i_t_ready  (tReady),
    .o_t_type   (tType),
    .o_t_addr   (tAddr),
    .o_t_data   (tData),
    .o_t_ts     (tTs),
    .o_t_count  (tCount),
    .o_halt     (halt),
    .o_tout     (tout),
    .o_ovf      (ovf),
    .o_drops    (drops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt++;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete bus cycle; returns on the falling edge after the release was sampled.
  task automatic applyStimulus(input logic [2:0] st, input logic [15:0] a, input logic [7:0] d,
                               input int stb, input int len);
    @(negedge clk);
    ale = 1'b1; {iom_, s1, s0} = st; addrHi = a[15:8]; addrdata = a[7:0];
    @(negedge clk);
    ale = 1'b0; addrdata = d;
    @(negedge clk);
    case (stb)
      STB_RD:  rd_ = 1'b0;
      STB_WR:  wr_ = 1'b0;
      default: inta_ = 1'b0;
    endcase
    repeat (len - 1) @(negedge clk);
    @(negedge clk);
    rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
    @(negedge clk);
    addrdata = 8'hEE;
  endtask

  task automatic pulseClr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    int c0;
    int c1;
    int expTs;

    vecs[0] = '{3'b011, 16'h0000, 8'h3E, STB_RD,   1, OPF,  16'h0000, 8'h3E};
    vecs[1] = '{3'b010, 16'h0001, 8'h55, STB_RD,   1, MRD,  16'h0001, 8'h55};
    vecs[2] = '{3'b001, 16'h2000, 8'hA5, STB_WR,   2, MWR,  16'h2000, 8'hA5};
    vecs[3] = '{3'b101, 16'h1010, 8'h7F, STB_WR,   1, IOWR, 16'h1010, 8'h7F};
    vecs[4] = '{3'b110, 16'h2020, 8'h9C, STB_RD,   3, IORD, 16'h2020, 8'h9C};
    vecs[5] = '{3'b111, 16'h0038, 8'hFF, STB_INTA, 1, INTA, 16'h0038, 8'hFF};
    vecs[6] = '{3'b100, 16'h1234, 8'h5A, STB_RD,   1, UNK,  16'h1234, 8'h5A};
    vecs[7] = '{3'b011, 16'hFFFF, 8'h00, STB_RD,   2, OPF,  16'hFFFF, 8'h00};

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", tValid, 0);
    checkOutput("rst_count", tCount, 0);
    checkOutput("rst_flags", {halt, tout, ovf}, 0);
    checkOutput("rst_drops", drops, 0);
    checkOutput("rst_rec",   {tType, tAddr, tData}, 0);
    checkOutput("rst_ts",    tTs, 0);
    rst = 1'b0;

    $display("[TB] table-driven single cycles");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].st, vecs[i].a, vecs[i].d, vecs[i].stb, vecs[i].len);
      checkOutput($sformatf("v%0d_latency", i), tValid, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", i), tValid, 1);
      checkOutput($sformatf("v%0d_type", i),  tType, vecs[i].expType);
      checkOutput($sformatf("v%0d_addr", i),  tAddr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d_data", i),  tData, vecs[i].expData);
      checkOutput($sformatf("v%0d_count", i), tCount, 1);
`ifndef TRACE_TS_EN
      checkOutput($sformatf("v%0d_ts", i), tTs, 0);
`endif
      tReady = 1'b1;
      @(negedge clk);
      tReady = 1'b0;
      checkOutput($sformatf("v%0d_popped", i), {tValid, tCount}, 0);
      checkOutput($sformatf("v%0d_empty_data", i), tData, 0);
    end
    checkOutput("table_no_halt", halt, 0);

    $display("[TB] two queued records");
    applyStimulus(3'b011, 16'h0000, 8'h3E, STB_RD, 1);
    applyStimulus(3'b010, 16'h0001, 8'h55, STB_RD, 1);
    @(negedge clk);
    checkOutput("q_count", tCount, 2);
    checkOutput("q_head", {tType, tAddr, tData}, {OPF, 16'h0000, 8'h3E});
    tReady = 1'b1; @(negedge clk); tReady = 1'b0;
    checkOutput("q_second", {tType, tAddr, tData}, {MRD, 16'h0001, 8'h55});
    tReady = 1'b1; @(negedge clk); tReady = 1'b0;

    $display("[TB] HLT fetch");
    applyStimulus(3'b011, 16'h0100, 8'h76, STB_RD, 1);
    @(negedge clk);
    checkOutput("hlt_rec", {tValid, tType, tData}, {1'b1, OPF, 8'h76});
    checkOutput("hlt_flag", halt, 1);
    tReady = 1'b1; @(negedge clk); tReady = 1'b0;
    applyStimulus(3'b010, 16'h0200, 8'h11, STB_RD, 1);
    repeat (2) @(negedge clk);
    checkOutput("hlt_suppress", {tValid, tCount}, 0);
    checkOutput("hlt_sticky", halt, 1);
    pulseClr();
    checkOutput("clr_halt", halt, 0);

    $display("[TB] overflow");
    for (int i = 0; i < 20; i++)
      applyStimulus(3'b001, 16'(16'h3000 + i), 8'(i), STB_WR, 1);
    @(negedge clk);
    checkOutput("ovf_count", tCount, 16);
    checkOutput("ovf_flag",  ovf, 1);
    checkOutput("ovf_drops", drops, 4);
    checkOutput("ovf_head",  {tAddr, tData}, {16'h3000, 8'h00});
    applyStimulus(3'b001, 16'h3099, 8'h99, STB_WR, 1);
    tReady = 1'b1;
    @(negedge clk);
    tReady = 1'b0;
    checkOutput("full_pp_count", tCount, 16);
    checkOutput("full_pp_drops", drops, 4);
    checkOutput("full_pp_head",  {tAddr, tData}, {16'h3001, 8'h01});
    tReady = 1'b1;
    repeat (15) @(negedge clk);
    tReady = 1'b0;
    checkOutput("full_pp_last", {tAddr, tData}, {16'h3099, 8'h99});
    tReady = 1'b1; @(negedge clk); tReady = 1'b0;
    checkOutput("drain_empty", {tValid, tCount}, 0);
    pulseClr();
    checkOutput("clr_ovf", {ovf, drops}, 0);

    $display("[TB] watchdog");
    applyStimulus(3'b010, 16'h5000, 8'h42, STB_RD, 1);
    @(negedge clk);
    checkOutput("wd_rec", tValid, 1);
    repeat (149) @(negedge clk);
    checkOutput("wd_before", tout, 0);
    @(negedge clk);
    checkOutput("wd_expire", tout, 1);
    repeat (5) @(negedge clk);
    checkOutput("wd_hold", tout, 1);
    pulseClr();
    checkOutput("wd_clr", {tout, tValid}, 0);

    $display("[TB] reset mid-cycle");
    applyStimulus(3'b010, 16'h4100, 8'h21, STB_RD, 1);
    @(negedge clk);
    checkOutput("pre_rst_count", tCount, 1);
    ale = 1'b1; {iom_, s1, s0} = 3'b010; addrHi = 8'h40; addrdata = 8'h00;
    @(negedge clk);
    ale = 1'b0; addrdata = 8'h66;
    @(negedge clk);
    rd_ = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out", {tValid, tCount, tType, tAddr, tData}, 0);
    checkOutput("rst_mid_flags", {halt, tout, ovf, drops}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_ = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("aborted_absent", {tValid, tCount}, 0);
    applyStimulus(3'b010, 16'h4444, 8'h77, STB_RD, 1);
    checkOutput("post_rst_latency", tValid, 0);
    @(negedge clk);
    checkOutput("post_rst_rec", {tValid, tType, tAddr, tData}, {1'b1, MRD, 16'h4444, 8'h77});
    checkOutput("post_rst_count", tCount, 1);

`ifdef TRACE_TS_EN
    $display("[TB] timestamps");
    pulseClr();
    c0 = edgeCnt;
    applyStimulus(3'b010, 16'h6000, 8'h01, STB_RD, 1);
    @(negedge clk);
    c1 = edgeCnt;
    expTs = c1 - c0 - 1;
    checkOutput("ts_first", tTs, 32'(expTs));
    @(negedge clk);
    applyStimulus(3'b010, 16'h6001, 8'h02, STB_RD, 1);
    @(negedge clk);
    tReady = 1'b1; @(negedge clk); tReady = 1'b0;
    checkOutput("ts_second_rec", tData, 8'h02);
    checkOutput("ts_second", tTs, 32'(expTs + 7));
`else
    c0 = 0; c1 = 0; expTs = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
